// File: rtl/save_pkg.sv
// Shared types and constants for the serial save capture path (ACIA transmit -> HPS upload).
package save_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ARMED   = 2'd2,
        UPLOAD  = 2'd3
    } save_state_t;

    localparam logic [7:0] NUL_BYTE            = 8'h00;
    localparam int         DEFAULT_DEPTH       = 16384;
    localparam int         DEFAULT_IDLE_CYCLES = 48000000;

    // Address lies inside the captured region; upper address bits are part of the compare.
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] count);
        return (addr < count);
    endfunction

endpackage

// File: rtl/save_buffer_ram.sv
// DEPTH x 8 single-port buffer RAM with registered read and a synchronous clear of the read register.
module save_buffer_ram #(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic              q_clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        q
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    // Write port: contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Read register: clear has priority, a write in the same cycle suppresses the read.
    always_ff @(posedge clk) begin
        if (q_clr) begin
            r_q <= 8'h00;
        end else if (re && !we) begin
            r_q <= r_mem[addr];
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serial_save_capture.sv
// Captures ACIA transmit bytes into a buffer and serves them to hps_io as an upload file.
// Optional build macro SAVE_STRIP_NUL_EN discards 0x00 padding bytes instead of storing them.
module serial_save_capture
    import save_pkg::*;
#(
    parameter int  DEPTH       = DEFAULT_DEPTH,
    parameter int  IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
    parameter int  TIMER_W     = 26,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              capture_en,
    input  logic [7:0]        tx_data,
    input  logic              tx_strobe,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [15:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              upload_req,
    output logic [ADDR_W:0]   byte_count,
    output logic              overflow,
    output logic              busy
);

    localparam int                 CNT_W      = ADDR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(IDLE_CYCLES - 1);

    save_state_t        r_state;
    logic [CNT_W-1:0]   r_byte_count;
    logic [TIMER_W-1:0] r_timer;
    logic               r_upload_req;
    logic               r_overflow;
    logic               r_busy;

    logic               w_accept;
    logic               w_keep;
    logic               w_full;
    logic               w_addr_ok;
    logic               w_we;
    logic               w_re;
    logic               w_q_clr;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [31:0]        w_addr_ext;
    logic [7:0]         w_ram_q;

    assign w_full     = (r_byte_count == FULL_COUNT);
    assign w_addr_ext = 32'(ioctl_addr);
    assign w_addr_ok  = addr_in_range(w_addr_ext, 32'(r_byte_count));

    // Byte qualification: accepted bytes reset the timer, kept bytes are the ones stored.
    always_comb begin
        w_accept = tx_strobe & capture_en;
`ifdef SAVE_STRIP_NUL_EN
        w_keep = w_accept && (tx_data != NUL_BYTE);
`else
        w_keep = w_accept;
`endif
    end

    // RAM port steering: writes only while filling, reads only while uploading.
    always_comb begin
        w_we       = 1'b0;
        w_re       = 1'b0;
        w_ram_addr = r_byte_count[ADDR_W-1:0];
        if (reset) begin
            w_we = 1'b0;
            w_re = 1'b0;
        end else begin
            case (r_state)
                IDLE:    w_we = w_keep;
                CAPTURE: w_we = w_keep && !w_full;
                UPLOAD: begin
                    w_re       = ioctl_rd;
                    w_ram_addr = w_addr_ext[ADDR_W-1:0];
                end
                default: begin
                    w_we = 1'b0;
                    w_re = 1'b0;
                end
            endcase
        end
        // Out-of-range reads and reset both force the read register to zero.
        w_q_clr = reset || (w_re && !w_addr_ok);
    end

    save_buffer_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clk   (clk_sys),
        .we    (w_we),
        .re    (w_re),
        .q_clr (w_q_clr),
        .addr  (w_ram_addr),
        .wdata (tx_data),
        .q     (w_ram_q)
    );

    // Control FSM with idle timer, byte counter and registered status outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= IDLE;
            r_byte_count <= '0;
            r_timer      <= '0;
            r_upload_req <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_upload_req <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_keep) begin
                        r_byte_count <= CNT_W'(1);
                        r_timer      <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        if (w_keep && w_full) begin
                            r_overflow <= 1'b1;
                        end else if (w_keep) begin
                            r_byte_count <= r_byte_count + CNT_W'(1);
                        end
                    end else if (!capture_en || (r_timer == TIMER_LAST)) begin
                        r_upload_req <= 1'b1;
                        r_state      <= ARMED;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ARMED: begin
                    if (ioctl_upload) begin
                        r_state <= UPLOAD;
                    end
                end
                UPLOAD: begin
                    if (!ioctl_upload) begin
                        r_byte_count <= '0;
                        r_overflow   <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ioctl_din  = w_ram_q;
    assign upload_req = r_upload_req;
    assign byte_count = r_byte_count;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule

// File: tb/tb_serial_save_capture.sv
// Scoreboard bench for serial_save_capture with DEPTH=16 and a 1000-cycle idle timeout.
module tb_serial_save_capture;

    localparam int DEPTH  = 16;
    localparam int IDLE   = 1000;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              capture_en;
    logic [7:0]        tx_data;
    logic              tx_strobe;
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [15:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              upload_req;
    logic [ADDR_W:0]   byte_count;
    logic              overflow;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_req_q[$];
    logic [7:0] exp_din_q[$];

    serial_save_capture #(
        .DEPTH       (DEPTH),
        .IDLE_CYCLES (IDLE),
        .TIMER_W     (11)
    ) dut (
        .clk_sys      (clk),
        .reset        (reset),
        .capture_en   (capture_en),
        .tx_data      (tx_data),
        .tx_strobe    (tx_strobe),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .upload_req   (upload_req),
        .byte_count   (byte_count),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples ioctl_rd at the edge, checks outputs on the following falling edge.
    initial begin
        logic rd_at_edge;
        forever begin
            @(posedge clk);
            rd_at_edge = ioctl_rd;
            @(negedge clk);
            if (upload_req === 1'b1) begin
                if (exp_req_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL upload_req_spurious: got pulse at cycle %0d, want none", cyc);
                end else begin
                    check("upload_req_cycle", cyc, exp_req_q.pop_front());
                end
            end
            if (rd_at_edge === 1'b1) begin
                if (exp_din_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ioctl_din_unexpected: got %0h with no expected read", ioctl_din);
                end else begin
                    check("ioctl_din", ioctl_din, exp_din_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output int n);
        tx_data   = b;
        tx_strobe = 1'b1;
        tick(1);
        tx_strobe = 1'b0;
        n = cyc;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e);
        exp_din_q.push_back(e);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd   = 1'b0;
    endtask

    task automatic drop_enable();
        capture_en = 1'b0;
        exp_req_q.push_back(cyc + 1);
        tick(1);
        capture_en = 1'b1;
    endtask

    task automatic start_upload();
        ioctl_upload = 1'b1;
        tick(1);
    endtask

    task automatic stop_upload(input string name);
        ioctl_upload = 1'b0;
        tick(2);
        check({name, "_end_busy"}, busy, 0);
        check({name, "_end_count"}, byte_count, 0);
        check({name, "_end_ovf"}, overflow, 0);
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        capture_en   = 1'b0;
        tx_data      = 8'h00;
        tx_strobe    = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 16'h0000;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_count", byte_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_req", upload_req, 0);
        check("rst_din", ioctl_din, 0);
        reset = 1'b0;
        tick(2);

        // Capture and upload via idle timeout
        capture_en = 1'b1;
        send(8'h31, n);
        tick(99);
        send(8'h30, n);
        tick(99);
        send(8'h0D, n);
        exp_req_q.push_back(n + IDLE);
        check("cap_count", byte_count, 3);
        check("cap_busy", busy, 1);
        tick(IDLE + 2);
        check("armed_busy", busy, 1);
        start_upload();
        rd(16'd0, 8'h31);
        rd(16'd1, 8'h30);
        rd(16'd2, 8'h0D);
        rd(16'd3, 8'h00);
        rd(16'h0100, 8'h00);
        stop_upload("cap");

        // Overflow: 20 bytes into a 16-byte buffer
        for (int i = 0; i < 20; i++) begin
            send(8'h40 + 8'(i), n);
        end
        exp_req_q.push_back(n + IDLE);
        check("ovf_count", byte_count, 16);
        check("ovf_flag", overflow, 1);
        tick(IDLE + 2);
        start_upload();
        for (int i = 0; i < 16; i++) begin
            rd(16'(i), 8'h40 + 8'(i));
        end
        rd(16'd16, 8'h00);
        stop_upload("ovf");

        // Strobe coincides with the last timer cycle
        send(8'h55, n);
        tick(IDLE - 1);
        send(8'h66, n);
        check("tie_count", byte_count, 2);
        exp_req_q.push_back(n + IDLE);
        tick(IDLE + 2);
        start_upload();
        rd(16'd0, 8'h55);
        rd(16'd1, 8'h66);
        stop_upload("tie");

        // capture_en drop after 5 bytes, then a strobe while armed
        for (int i = 0; i < 5; i++) begin
            send(8'h10 + 8'(i), n);
        end
        drop_enable();
        tick(2);
        send(8'h77, n);
        check("drop_armed_count", byte_count, 5);
        start_upload();
        for (int i = 0; i < 5; i++) begin
            rd(16'(i), 8'h10 + 8'(i));
        end
        rd(16'd5, 8'h00);
        stop_upload("drop");

        // Reset during upload
        send(8'h21, n);
        send(8'h22, n);
        drop_enable();
        tick(1);
        start_upload();
        rd(16'd1, 8'h22);
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        tick(1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", byte_count, 0);
        check("mid_rst_din", ioctl_din, 0);
        reset = 1'b0;
        tick(1);
        send(8'h99, n);
        check("post_rst_count", byte_count, 1);
        drop_enable();
        tick(1);
        start_upload();
        rd(16'd0, 8'h99);
        rd(16'd1, 8'h00);
        stop_upload("post_rst");

        // NUL padding handling
        send(8'h00, n);
        send(8'h41, n);
        send(8'h00, n);
        send(8'h42, n);
`ifdef SAVE_STRIP_NUL_EN
        check("nul_count", byte_count, 2);
`else
        check("nul_count", byte_count, 4);
`endif
        drop_enable();
        tick(1);
        start_upload();
`ifdef SAVE_STRIP_NUL_EN
        rd(16'd0, 8'h41);
        rd(16'd1, 8'h42);
        rd(16'd2, 8'h00);
`else
        rd(16'd0, 8'h00);
        rd(16'd1, 8'h41);
        rd(16'd2, 8'h00);
        rd(16'd3, 8'h42);
        rd(16'd4, 8'h00);
`endif
        stop_upload("nul");

        tick(5);
        check("req_queue_left", exp_req_q.size(), 0);
        check("din_queue_left", exp_din_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_save_capture.md
Name: serial_save_capture

Overview:
- Reverse path of the ASCII/program load path: saves program text the machine sends out, instead of loading it in.
- Captures every byte the machine's ACIA transmits while capture is enabled (BASIC SAVE/LIST output) into an on-chip buffer.
- After a quiet period, raises an upload request to hps_io and serves the buffer to the HPS as a file over the ioctl upload interface.
- Sits in the top level between the uk101 core's ACIA transmit strobe and hps_io's ioctl_upload/ioctl_rd/ioctl_din.

Parameters:
- DEPTH, 16384, buffer size in bytes; must be a power of two. ADDR_W = $clog2(DEPTH) is derived.
- IDLE_CYCLES, 48000000, number of clk_sys cycles with no transmitted byte that ends a capture (1 s at 48 MHz).
- TIMER_W, 26, width of the idle timer; must satisfy 2^TIMER_W > IDLE_CYCLES.

Ports:
- clk_sys  in  1  system clock (48 MHz)
- reset  in  1  synchronous, active-high reset
- capture_en  in  1  OSD "save" enable, level
- tx_data  in  8  byte loaded into the ACIA transmit register
- tx_strobe  in  1  one-cycle pulse; tx_data is valid in that cycle
- ioctl_upload  in  1  high while hps_io performs the upload
- ioctl_rd  in  1  hps_io read strobe
- ioctl_addr  in  16  upload byte address
- ioctl_din  out  8  read data to hps_io
- upload_req  out  1  one-cycle pulse to hps_io ioctl_upload_req
- byte_count  out  ADDR_W+1  number of bytes captured
- overflow  out  1  sticky flag: a byte was dropped because the buffer was full
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all of the following take effect in the cycle after reset is sampled high, regardless of the current state.
  - State goes to IDLE.
  - ioctl_din=0, upload_req=0, byte_count=0, overflow=0, busy=0, timer=0.
  - Buffer contents are not cleared.
- States: IDLE, CAPTURE, ARMED, UPLOAD.
- A byte is "accepted" when tx_strobe=1 and capture_en=1.
- IDLE:
  - Accepted byte: written to mem[0], byte_count=1, timer=0, go to CAPTURE.
- CAPTURE:
  - Accepted byte with byte_count<DEPTH: written to mem[byte_count], byte_count++, timer=0.
  - Accepted byte with byte_count==DEPTH: byte dropped, overflow=1, timer=0.
  - Cycle with no strobe: timer++.
  - timer==IDLE_CYCLES-1 with no strobe in that cycle: upload_req=1 for exactly one cycle, go to ARMED.
  - capture_en low: the same end-of-capture action occurs on the next cycle, without waiting for the timer.
  - Strobe and timer expiry in the same cycle: the strobe wins; the byte is accepted and timer=0.
- ARMED:
  - tx_strobe is ignored.
  - Stays in ARMED indefinitely until ioctl_upload=1, then goes to UPLOAD.
  - upload_req is not repeated.
- UPLOAD:
  - When ioctl_rd=1, ioctl_din is registered one cycle later.
  - ioctl_din = mem[ioctl_addr[ADDR_W-1:0]] if ioctl_addr < byte_count; otherwise 0x00.
  - ioctl_addr bits at and above ADDR_W that are nonzero also count as out of range.
  - When ioctl_upload falls, the next cycle goes to IDLE with byte_count=0 and overflow=0.
  - Strobes are ignored throughout UPLOAD.
- Buffer: single-port inferred block RAM with write priority. The write port is used only in IDLE/CAPTURE and the read port only in UPLOAD, so no read/write collision is possible.
- byte_count saturates at DEPTH and never wraps.
- All outputs are registered.

Optional Feature:
- Macro: SAVE_STRIP_NUL_EN.
- Defined: accepted bytes equal to 0x00 (the UK101 BASIC NUL padding) are discarded.
  - They are not written and do not advance byte_count.
  - They still reset the idle timer.
  - In IDLE, a 0x00 byte does not start a capture.
- Undefined: every accepted byte is stored verbatim.

Decomposition:
- Shared package save_pkg:
  - state enum typedef save_state_t {IDLE, CAPTURE, ARMED, UPLOAD}.
  - localparam NUL_BYTE = 8'h00.
  - localparam for the default IDLE_CYCLES at 48 MHz.
- One sub-module, save_buffer_ram: parameterised DEPTH x 8 single-port RAM with a registered read.
- FSM, timer and counters stay in serial_save_capture.

Test Plan:
- Capture and upload:
  - Stimulus: capture_en=1; strobe 0x31,0x30,0x0D spaced 100 cycles apart; IDLE_CYCLES=1000 for the bench.
  - Required: upload_req pulses exactly once, 1000 cycles after the last strobe; byte_count=3.
  - Then raise ioctl_upload and read addresses 0..3: ioctl_din = 0x31,0x30,0x0D,0x00, each one cycle after its ioctl_rd.
- Overflow:
  - Stimulus: DEPTH=16; strobe 20 bytes.
  - Required: byte_count=16, overflow=1; upload returns the first 16 bytes.
- Timer tie:
  - Stimulus: strobe arrives in the cycle where timer==IDLE_CYCLES-1.
  - Required: no upload_req; byte is stored; timer restarts from 0.
- capture_en drop:
  - Stimulus: capture_en falls mid-capture after 5 bytes.
  - Required: upload_req pulses the next cycle; a strobe in ARMED leaves byte_count=5.
- Reset mid-upload:
  - Stimulus: assert reset during UPLOAD.
  - Required: next cycle busy=0, byte_count=0, ioctl_din=0; a new strobe starts capture at address 0.
- SAVE_STRIP_NUL_EN:
  - Stimulus: strobe 0x00,0x41,0x00,0x42.
  - Required with macro defined: byte_count=2, data 0x41,0x42.
  - Required with macro undefined: byte_count=4.
